scpu_word_mem_serdes: RTL

Word-wide program/data memory that sits directly upstream of the 8-bit serial CPU core and supplies its byte-serial instruction and data buses. The memory stores 16-bit words. A fetch returns the low byte, then the high byte, on consecutive cycles. A CPU store delivers two bytes, low then high, and the block assembles them into one word before committing it. A host load port preloads whole words, which replaces hand-driven byte stimulus in system benches.

---
 rtl/scpu_mem_pkg.sv | 19 +
 rtl/scpu_word_mem_serdes_if.sv | 31 +++
 rtl/scpu_word_ram.sv | 28 ++
 rtl/scpu_word_mem_serdes.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/scpu_mem_pkg.sv
// Shared types and constants for the word memory that feeds the serial CPU core.
package scpu_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // rd_hi encoding for the two read beats.
  localparam logic BEAT_LO = 1'b0;
  localparam logic BEAT_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_MEM = 3'd1,
    RD_LO  = 3'd2,
    RD_HI  = 3'd3,
    WR_HI  = 3'd4
  } state_t;

endpackage

// File: rtl/scpu_word_mem_serdes_if.sv
// Byte-serial fetch, byte-serial store and host word-load signals of the word memory.
interface scpu_word_mem_serdes_if #(
  parameter int ADDR_W = 9
);

  logic              ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_hi;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_byte;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_word;
  logic              ld_ack;
  logic              err;

  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_byte, ld_en, ld_addr, ld_word,
    output ready, rd_data, rd_valid, rd_hi, ld_ack, err
  );

  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_byte, ld_en, ld_addr, ld_word,
    input  ready, rd_data, rd_valid, rd_hi, ld_ack, err
  );

endinterface

// File: rtl/scpu_word_ram.sv
// Single-port DEPTH x DW RAM, synchronous read and write, no reset (block-RAM template).
module scpu_word_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scpu_word_mem_serdes.sv
// 16-bit word memory with a byte-serial fetch port, a byte-pair store port
// and a host word-load port, sequenced by one small FSM.
//
// state  | meaning
// IDLE   | ready; arbitrates wr_en > rd_req > ld_en
// RD_MEM | RAM read of the captured fetch address
// RD_LO  | low byte beat on rd_data
// RD_HI  | high byte beat on rd_data
// WR_HI  | low byte held, waiting for the high byte or timeout
module scpu_word_mem_serdes
  import scpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int WORD_W     = 16,
  parameter int WR_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  scpu_word_mem_serdes_if.slave bus
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WR_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_oor_q, rd_oor_d;
  logic [RAM_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_lo_q, wr_lo_d;
  logic                wr_oor_q, wr_oor_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ld_ack_q, ld_ack_d;
  logic                err_q, err_d;

  logic                ram_we, ram_re;
  logic [RAM_AW-1:0]   ram_addr;
  logic [WORD_W-1:0]   ram_wdata, ram_rdata;

  logic rd_in_range, wr_in_range, ld_in_range;

  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign ld_in_range = ({1'b0, bus.ld_addr} < DEPTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_oor_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_lo_q   <= '0;
      wr_oor_q  <= 1'b0;
      cnt_q     <= '0;
      ld_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_oor_q  <= rd_oor_d;
      wr_addr_q <= wr_addr_d;
      wr_lo_q   <= wr_lo_d;
      wr_oor_q  <= wr_oor_d;
      cnt_q     <= cnt_d;
      ld_ack_q  <= ld_ack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_oor_d  = rd_oor_q;
    wr_addr_d = wr_addr_q;
    wr_lo_d   = wr_lo_q;
    wr_oor_d  = wr_oor_q;
    cnt_d     = cnt_q;
    ld_ack_d  = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = rd_addr_q;
    ram_wdata = bus.ld_word;

    unique case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          wr_addr_d = bus.wr_addr[RAM_AW-1:0];
          wr_lo_d   = bus.wr_byte;
          wr_oor_d  = !wr_in_range;
          cnt_d     = '0;
          state_d   = WR_HI;
        end else if (bus.rd_req) begin
          rd_addr_d = bus.rd_addr[RAM_AW-1:0];
          rd_oor_d  = !rd_in_range;
          state_d   = RD_MEM;
        end else if (bus.ld_en) begin
          ld_ack_d = 1'b1;
          if (ld_in_range) begin
            ram_we    = 1'b1;
            ram_addr  = bus.ld_addr[RAM_AW-1:0];
            ram_wdata = bus.ld_word;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD_MEM: begin
        ram_re   = 1'b1;
        ram_addr = rd_addr_q;
        state_d  = RD_LO;
      end
      RD_LO: state_d = RD_HI;
      RD_HI: state_d = IDLE;
      WR_HI: begin
        if (bus.wr_en) begin
          if (!wr_oor_q) begin
            ram_we    = 1'b1;
            ram_addr  = wr_addr_q;
            ram_wdata = {bus.wr_byte, wr_lo_q};
          end else begin
            err_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_TC) begin
          // Idle edge that would bring the count to WR_TIMEOUT: drop the half store.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the write strobe so no write can land while rst is held.
  scpu_word_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW),
    .DW    (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we & ~rst),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  logic beat_valid;
  assign beat_valid = (state_q == RD_LO) || (state_q == RD_HI);

  assign bus.ready    = (state_q == IDLE);
  assign bus.rd_valid = beat_valid;
  assign bus.rd_hi    = (state_q == RD_HI) ? BEAT_HI : BEAT_LO;
  assign bus.rd_data  = (!beat_valid || rd_oor_q) ? '0 :
                        (state_q == RD_HI) ? ram_rdata[WORD_W-1:BYTE_W] :
                                             ram_rdata[BYTE_W-1:0];
  assign bus.ld_ack   = ld_ack_q;
  assign bus.err      = err_q | ((state_q == RD_LO) && rd_oor_q);

endmodule
